stream_buffer: RTL and testbench

STREAM_BUFFER -- requirements
Module: stream_buffer

---
 rtl/stream_buffer.sv | 130 +++++++++++++
 tb/tb_stream_buffer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/stream_buffer.sv
// Purpose: single-clock element FIFO, one element written per cycle, LANES elements popped per read.
// Latency: write visible to reads from the next cycle; rd_data/rd_valid register one edge after an accepted read.
// Backpressure: writes when full and reads with fewer than LANES stored are dropped and flagged by sticky overflow/underflow.
module stream_buffer #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 16384,
    parameter  int LANES  = 2,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    wr_en,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    rd_en,
    output logic [LANES*DATA_W-1:0] rd_data,
    output logic                    rd_valid,
    output logic                    full,
    output logic                    empty,
    output logic [AW:0]             count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LANES_C = (AW+1)'(LANES);
    localparam logic [AW-1:0] LANES_P = AW'(LANES);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [AW:0]               count_q, count_d;
    logic                      rd_valid_q, rd_valid_d;
    logic [LANES*DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                      overflow_q, overflow_d;
    logic                      underflow_q, underflow_d;

    logic                      wr_ok;
    logic                      rd_ok;
    logic                      mem_we;
    logic [LANES*DATA_W-1:0]   rd_group;

    // Gather the group starting at rd_ptr; oldest element lands in the most significant lane.
    always_comb begin
        rd_group = '0;
        for (int k = 0; k < LANES; k++) begin
            rd_group[(LANES-1-k)*DATA_W +: DATA_W] = mem[rd_ptr_q + AW'(k)];
        end
    end

    // Acceptance decisions use the start-of-cycle count, so a read never frees space for a same-cycle write.
    always_comb begin
        wr_ok  = wr_en && (count_q != DEPTH_C);
        rd_ok  = rd_en && (count_q >= LANES_C);
        mem_we = wr_ok && !clear;
    end

    // Next-state for pointers, count, read output register and sticky error flags; clear wins over everything.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            rd_data_d   = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_d   = rd_ptr_q + LANES_P;
                rd_valid_d = 1'b1;
                rd_data_d  = rd_group;
            end
            count_d = count_q + (AW+1)'(wr_ok) - (rd_ok ? LANES_C : '0);
            if (wr_en && !wr_ok) begin
                overflow_d = 1'b1;
            end
            if (rd_en && !rd_ok) begin
                underflow_d = 1'b1;
            end
        end
    end

    // Control and output registers, asynchronously reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array has no reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign count     = count_q;
    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q < LANES_C);
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_stream_buffer.sv
// Purpose: directed checks of stream_buffer with DATA_W=32, DEPTH=8, LANES=2.
// Latency: inputs applied 1ns after a rising edge, outputs checked 1ns after the next one.
// Backpressure: exercises full/overflow and empty/underflow corners plus async reset.
module tb_stream_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [63:0] rd_data;
    logic        rd_valid;
    logic        full;
    logic        empty;
    logic [3:0]  count;
    logic        overflow;
    logic        underflow;

    int n_checks = 0;
    int n_err    = 0;

    stream_buffer #(.DATA_W(32), .DEPTH(8), .LANES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic we, input logic [31:0] wd, input logic re, input logic cl);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        clear   = cl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_underflow", underflow, 0);
        rst = 1'b0;

        // Basic write 1..4, two reads
        for (int i = 1; i <= 4; i++) step(1, 32'(i), 0, 0);
        chk("basic_count4", count, 4);
        step(0, 0, 1, 0);
        chk("basic_rd0_data", rd_data, 64'h00000001_00000002);
        chk("basic_rd0_valid", rd_valid, 1);
        chk("basic_rd0_count", count, 2);
        step(0, 0, 1, 0);
        chk("basic_rd1_data", rd_data, 64'h00000003_00000004);
        chk("basic_rd1_valid", rd_valid, 1);
        chk("basic_rd1_count", count, 0);
        chk("basic_rd1_empty", empty, 1);
        step(0, 0, 0, 0);
        chk("basic_idle_valid", rd_valid, 0);
        chk("basic_idle_hold", rd_data, 64'h00000003_00000004);

        // Underflow with one element stored
        step(1, 32'h5, 0, 0);
        chk("uf_empty_one", empty, 1);
        step(0, 0, 1, 0);
        chk("uf_flag", underflow, 1);
        chk("uf_valid", rd_valid, 0);
        chk("uf_count", count, 1);
        chk("uf_data_hold", rd_data, 64'h00000003_00000004);
        step(0, 0, 0, 1);
        chk("clr_count", count, 0);
        chk("clr_underflow", underflow, 0);
        chk("clr_rd_data", rd_data, 0);

        // Fill, overflow, full with simultaneous read
        for (int i = 0; i < 8; i++) step(1, 32'h10 + 32'(i), 0, 0);
        chk("full_count", count, 8);
        chk("full_flag", full, 1);
        chk("full_of_before", overflow, 0);
        step(1, 32'h99, 0, 0);
        chk("of_flag", overflow, 1);
        chk("of_count", count, 8);
        step(1, 32'h99, 1, 0);
        chk("fullboth_count", count, 6);
        chk("fullboth_data", rd_data, 64'h00000010_00000011);
        chk("fullboth_full", full, 0);
        step(0, 0, 1, 0);
        chk("drain_a", rd_data, 64'h00000012_00000013);
        step(0, 0, 1, 0);
        chk("drain_b", rd_data, 64'h00000014_00000015);
        step(0, 0, 1, 0);
        chk("drain_c", rd_data, 64'h00000016_00000017);
        chk("drain_count", count, 0);
        chk("of_sticky", overflow, 1);
        step(0, 0, 0, 1);
        chk("clr_overflow", overflow, 0);

        // Wraparound: fill 1..8, read 6, write A..F, read 4 groups
        for (int i = 1; i <= 8; i++) step(1, 32'(i), 0, 0);
        step(0, 0, 1, 0);
        chk("wrap_r0", rd_data, 64'h00000001_00000002);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("wrap_r2", rd_data, 64'h00000005_00000006);
        chk("wrap_count2", count, 2);
        for (int i = 10; i <= 15; i++) step(1, 32'(i), 0, 0);
        chk("wrap_count8", count, 8);
        chk("wrap_full", full, 1);
        step(0, 0, 1, 0);
        chk("wrap_g0", rd_data, 64'h00000007_00000008);
        chk("wrap_g0_count", count, 6);
        step(0, 0, 1, 0);
        chk("wrap_g1", rd_data, 64'h0000000A_0000000B);
        step(0, 0, 1, 0);
        chk("wrap_g2", rd_data, 64'h0000000C_0000000D);
        step(0, 0, 1, 0);
        chk("wrap_g3", rd_data, 64'h0000000E_0000000F);
        chk("wrap_count0", count, 0);
        chk("wrap_no_uf", underflow, 0);

        // Count 4 with simultaneous write and read
        for (int i = 0; i < 4; i++) step(1, 32'h21 + 32'(i), 0, 0);
        chk("both4_pre", count, 4);
        step(1, 32'h25, 1, 0);
        chk("both4_count", count, 3);
        chk("both4_data", rd_data, 64'h00000021_00000022);
        step(0, 0, 1, 0);
        chk("both4_next", rd_data, 64'h00000023_00000024);
        chk("both4_count1", count, 1);

        // Refused read then streaming, then async reset between edges
        step(0, 0, 1, 0);
        chk("pre_rst_uf", underflow, 1);
        step(1, 32'h26, 0, 0);
        step(0, 0, 1, 0);
        chk("pre_rst_data", rd_data, 64'h00000025_00000026);
        chk("pre_rst_valid", rd_valid, 1);
        step(1, 32'h27, 1, 0);
        step(1, 32'h28, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_full", full, 0);
        chk("arst_valid", rd_valid, 0);
        chk("arst_data", rd_data, 0);
        chk("arst_uf", underflow, 0);
        chk("arst_of", overflow, 0);
        @(posedge clk);
        #1;
        chk("arst_edge_valid", rd_valid, 0);
        rst = 1'b0;

        // Pointers restart from zero after reset
        step(1, 32'h31, 0, 0);
        step(1, 32'h32, 0, 0);
        step(0, 0, 1, 0);
        chk("post_rst_data", rd_data, 64'h00000031_00000032);
        chk("post_rst_count", count, 0);
        step(0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
